// File: rtl/minmax_pkg.sv
// Shared types and the compare rule used by both the parallel and the
// streaming min/max blocks.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // Widest sample the shared compare function handles; callers extend
    // their W-bit samples to this width before calling minmax_wins.
    localparam int CMP_W = 64;

    // Value presented on the result port while no frame has completed.
    localparam logic [CMP_W-1:0] RESULT_RST = '0;

    // Returns 1 when a strictly beats b: less-than for min, greater-than
    // for max, signed or unsigned according to us.
    function automatic logic minmax_wins(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             us,
        input logic             mx
    );
        logic lt;
        logic gt;
        if (us) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        return mx ? gt : lt;
    endfunction

endpackage

// File: rtl/minmax_cmp.sv
// Combinational strict-win compare of two W-bit samples.
module minmax_cmp
    import minmax_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         us,
    input  logic         mx,
    output logic         win
);

    logic [CMP_W-1:0] a_ext;
    logic [CMP_W-1:0] b_ext;

    // Sign- or zero-extend so the wide compare matches a W-bit compare.
    always_comb begin
        if (us) begin
            a_ext = {{(CMP_W-W){a[W-1]}}, a};
            b_ext = {{(CMP_W-W){b[W-1]}}, b};
        end else begin
            a_ext = {{(CMP_W-W){1'b0}}, a};
            b_ext = {{(CMP_W-W){1'b0}}, b};
        end
    end

    assign win = minmax_wins(a_ext, b_ext, us, mx);

endmodule

// File: rtl/minmax_stream.sv
// Serial min/max tracker: one sample per accepted beat, up to NI samples
// per frame, result and winning index presented on a valid/ready port.
module minmax_stream
    import minmax_pkg::*;
#(
    parameter int W    = 12,
    parameter int NI   = 9,
    parameter int IDXW = $clog2(NI),
    parameter int CFG  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    input  logic            us_sel,
    input  logic            min_max_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    result,
    output logic [IDXW-1:0] index,
    output logic [IDXW:0]   count
);

    localparam logic [IDXW:0] CNT_MAX = (IDXW+1)'(NI);

    state_t          state;
    logic [W-1:0]    acc_val;
    logic [IDXW-1:0] acc_idx;
    logic [IDXW:0]   cnt;
    logic [IDXW:0]   cnt_inc;
    logic            frame_us;
    logic            frame_mx;
    logic            accept;
    logic            wins;

    // in_ready depends on state only, so there is no path from out_ready.
    assign in_ready = (state != DONE);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + (IDXW+1)'(1);

    minmax_cmp #(
        .W(W)
    ) u_cmp (
        .a  (in_data),
        .b  (acc_val),
        .us (frame_us),
        .mx (frame_mx),
        .win(wins)
    );

    assign result = acc_val;
    assign count  = cnt;
    assign index  = (CFG == 1) ? '0 : acc_idx;

    // Frame FSM: load on first beat, accumulate strict wins, hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            acc_val   <= RESULT_RST[W-1:0];
            acc_idx   <= '0;
            cnt       <= '0;
            frame_us  <= 1'b0;
            frame_mx  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_val  <= in_data;
                        acc_idx  <= '0;
                        cnt      <= (IDXW+1)'(1);
                        frame_us <= us_sel;
                        frame_mx <= min_max_sel;
                        if (in_last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (wins) begin
                            acc_val <= in_data;
                            acc_idx <= cnt[IDXW-1:0];
                        end
                        cnt <= cnt_inc;
                        if (in_last || (cnt_inc == CNT_MAX)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_stream.sv
// Randomised and directed bench for minmax_stream, run against a CFG=0
// and a CFG=1 instance sharing the same input stream.
module tb_minmax_stream;

    localparam int W    = 12;
    localparam int NI   = 9;
    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic            us_sel;
    logic            min_max_sel;
    logic            out_ready;
    logic            in_ready0, in_ready1;
    logic            out_valid0, out_valid1;
    logic [W-1:0]    result0, result1;
    logic [IDXW-1:0] index0, index1;
    logic [IDXW:0]   count0, count1;

    int compare_count  = 0;
    int mismatch_count = 0;

    logic [W-1:0] frame_data [NI];

    always #5 clk = ~clk;

    minmax_stream #(.W(W), .NI(NI), .IDXW(IDXW), .CFG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .us_sel(us_sel),
        .min_max_sel(min_max_sel), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .index(index0), .count(count0)
    );

    minmax_stream #(.W(W), .NI(NI), .IDXW(IDXW), .CFG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .us_sel(us_sel),
        .min_max_sel(min_max_sel), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .index(index1), .count(count1)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_count++;
        if (obs !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: numeric extreme of the frame, then its first occurrence.
    task automatic modelFrame(input int n, input bit us, input bit mx,
                              output logic [W-1:0] val, output int idx);
        int v [NI];
        int best;
        for (int i = 0; i < n; i++) begin
            if (us) v[i] = int'($signed(frame_data[i]));
            else    v[i] = int'(frame_data[i]);
        end
        best = v[0];
        for (int i = 1; i < n; i++) begin
            if (mx && v[i] > best) best = v[i];
            if (!mx && v[i] < best) best = v[i];
        end
        idx = -1;
        for (int i = n - 1; i >= 0; i--) begin
            if (v[i] == best) idx = i;
        end
        val = frame_data[idx];
    endtask

    // Drives n beats of frame_data starting at a falling edge.
    task automatic applyStimulus(input int n, input bit us, input bit mx,
                                 input bit last_on_final, input int toggle_at,
                                 input bit scramble, input int gap_max);
        bit closes;
        closes = (n == NI) || last_on_final;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = W'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame_data[i];
            in_last  = (i == n - 1) && last_on_final;
            if (i == 0) begin
                us_sel      = us;
                min_max_sel = mx;
                checkOutput("in_ready_first_beat", 32'(in_ready0), 32'd1);
                checkOutput("in_ready_first_beat_cfg1", 32'(in_ready1), 32'd1);
            end else if (scramble) begin
                us_sel      = 1'($urandom);
                min_max_sel = 1'($urandom);
            end else if (toggle_at >= 0 && i >= toggle_at) begin
                us_sel = ~us;
            end
            if (i == n - 1) begin
                checkOutput("out_valid_before_close", 32'(out_valid0), 32'd0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (closes) begin
            checkOutput("out_valid_latency", 32'(out_valid0), 32'd1);
            checkOutput("out_valid_latency_cfg1", 32'(out_valid1), 32'd1);
        end
    endtask

    // Checks the held result, applies stall cycles of backpressure, takes it.
    task automatic collectResult(input logic [W-1:0] exp_val, input int exp_idx,
                                 input int exp_cnt, input int stall);
        checkOutput("result", 32'(result0), 32'(exp_val));
        checkOutput("index", 32'(index0), 32'(exp_idx));
        checkOutput("count", 32'(count0), 32'(exp_cnt));
        checkOutput("result_cfg1", 32'(result1), 32'(exp_val));
        checkOutput("index_cfg1", 32'(index1), 32'd0);
        checkOutput("count_cfg1", 32'(count1), 32'(exp_cnt));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = W'($urandom);
            in_last   = 1'($urandom);
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(out_valid0), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready0), 32'd0);
            checkOutput("stall_result", 32'(result0), 32'(exp_val));
            checkOutput("stall_index", 32'(index0), 32'(exp_idx));
            checkOutput("stall_count", 32'(count0), 32'(exp_cnt));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("take_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("take_in_ready", 32'(in_ready0), 32'd1);
        checkOutput("take_in_ready_cfg1", 32'(in_ready1), 32'd1);
    endtask

    task automatic loadFrame(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                             input logic [W-1:0] d3, input logic [W-1:0] d4, input logic [W-1:0] d5,
                             input logic [W-1:0] d6, input logic [W-1:0] d7, input logic [W-1:0] d8);
        frame_data[0] = d0; frame_data[1] = d1; frame_data[2] = d2;
        frame_data[3] = d3; frame_data[4] = d4; frame_data[5] = d5;
        frame_data[6] = d6; frame_data[7] = d7; frame_data[8] = d8;
    endtask

    // Guards against a hung run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by the randomised sweep.
    initial begin
        logic [W-1:0] mval;
        int           midx;
        int           n;
        bit           us, mx, lst;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        us_sel      = 1'b0;
        min_max_sel = 1'b0;
        out_ready   = 1'b0;
        for (int i = 0; i < NI; i++) frame_data[i] = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("reset_result", 32'(result0), 32'd0);
        checkOutput("reset_index", 32'(index0), 32'd0);
        checkOutput("reset_count", 32'(count0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready0), 32'd1);

        loadFrame(12'h100, 12'h050, 12'hFFF, 12'h050, 12'h300, 12'h010, 12'h800, 12'h010, 12'h7FF);
        applyStimulus(NI, 1'b0, 1'b0, 1'b0, -1, 1'b0, 0);
        collectResult(12'h010, 5, 9, 0);
        applyStimulus(NI, 1'b1, 1'b1, 1'b1, -1, 1'b0, 0);
        collectResult(12'h7FF, 8, 9, 0);
        // 0x800 is -2048, the most negative sample of this frame.
        applyStimulus(NI, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0);
        collectResult(12'h800, 6, 9, 5);

        frame_data[0] = 12'd5; frame_data[1] = 12'd9; frame_data[2] = 12'd9;
        applyStimulus(3, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0);
        collectResult(12'd9, 1, 3, 0);

        loadFrame(12'h001, 12'hF00, 12'h010, 12'h020, 12'h030, 12'h040, 12'h050, 12'h060, 12'h070);
        applyStimulus(NI, 1'b1, 1'b0, 1'b0, 4, 1'b0, 0);
        collectResult(12'hF00, 1, 9, 0);

        frame_data[0] = 12'hABC;
        applyStimulus(1, 1'b1, 1'b1, 1'b1, -1, 1'b0, 0);
        collectResult(12'hABC, 0, 1, 0);

        // Reset mid-frame after four beats, then a fresh full frame.
        for (int i = 0; i < NI; i++) frame_data[i] = W'($urandom);
        applyStimulus(4, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("midreset_count", 32'(count0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) frame_data[i] = W'($urandom);
        applyStimulus(NI, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1);
        modelFrame(NI, 1'b1, 1'b0, mval, midx);
        collectResult(mval, midx, NI, 1);

        // Reset while a result is waiting: it must vanish at once.
        frame_data[0] = 12'h123; frame_data[1] = 12'h456;
        applyStimulus(2, 1'b0, 1'b1, 1'b1, -1, 1'b0, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("done_reset_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("done_reset_out_valid_cfg1", 32'(out_valid1), 32'd0);
        checkOutput("done_reset_result", 32'(result0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_out_valid", 32'(out_valid0), 32'd0);
        checkOutput("post_reset_in_ready", 32'(in_ready0), 32'd1);

        for (int f = 0; f < 1250; f++) begin
            n   = $urandom_range(NI, 1);
            us  = 1'($urandom);
            mx  = 1'($urandom);
            lst = (n < NI) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(1, 0) == 0) frame_data[i] = W'($urandom_range(3, 0) * 12'h555);
                else                           frame_data[i] = W'($urandom);
            end
            applyStimulus(n, us, mx, lst, -1, 1'b1, 2);
            modelFrame(n, us, mx, mval, midx);
            collectResult(mval, midx, n, $urandom_range(3, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
